// File: rtl/uart_cmd_rcv.sv
// 8N1 UART receiver for the host command link: synchronises RX, samples each bit
// at mid-period and presents bytes with sticky ready, framing-error and overrun flags.
module uart_cmd_rcv #(
    parameter int BAUD_DIV = 2604,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX,
    input  logic             clr_rdy,
    output logic [7:0]       rx_data,
    output logic             rdy,
    output logic             frame_err,
    output logic             overrun,
    output logic [2:0]       state_dbg
);

    // Consumer handshake: rdy rises when a well-framed byte lands in rx_data and
    // stays high until the consumer pulses clr_rdy for one cycle; a byte completing
    // in that same cycle takes precedence and leaves rdy high with overrun clear.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2);
    // Reloading with BAUD_DIV-1 makes the zero-to-zero spacing exactly BAUD_DIV clocks.
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BAUD_DIV - 1);

    state_t           state, state_n;
    logic             rx_m, rx_s;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       rx_data_n;
    logic             rdy_n, frame_err_n, overrun_n;
    logic             cnt_zero;

    assign cnt_zero  = (cnt == '0);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_m      <= RX;
            rx_s      <= rx_m;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            rx_data   <= rx_data_n;
            rdy       <= rdy_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        rx_data_n   = rx_data;
        rdy_n       = rdy;
        frame_err_n = frame_err;
        overrun_n   = overrun;

        if (clr_rdy) begin
            rdy_n       = 1'b0;
            overrun_n   = 1'b0;
            frame_err_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_n   = HALF_LOAD;
                    state_n = START;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    cnt_n     = BIT_LOAD;
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    cnt_n     = BIT_LOAD;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (rx_s) begin
                    rx_data_n   = shreg;
                    rdy_n       = 1'b1;
                    frame_err_n = 1'b0;
                    overrun_n   = (overrun || rdy) && !clr_rdy;
                    state_n     = IDLE;
                end else begin
                    frame_err_n = 1'b1;
                    state_n     = BRK;
                end
            end
            BRK: begin
                // A line held low after a bad stop bit must not restart a frame.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Bench for uart_cmd_rcv: serial driver, byte-level reference model with expected
// queue, per-cycle output compare and literal checks for each scenario.
module tb_uart_cmd_rcv;
  localparam int B   = 52;
  localparam int CW  = 6;
  localparam int LAT = 2 + B / 2 + 9 * B + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic [2:0] state_dbg;

  uart_cmd_rcv #(.BAUD_DIV(B), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .RX(rx),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy(rdy),
    .frame_err(frame_err),
    .overrun(overrun),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_ferr;
  logic       m_ovr;
  bit         chk_en = 1'b0;
  int         quiet = 0;
  int         lat_meas = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // byte-level model: a good frame delivers the next queued byte, a bad one flags
  task automatic model_frame(input bit good);
    if (good) begin
      if (m_rdy) m_ovr = 1'b1;
      m_data = exp_q.pop_front();
      m_rdy  = 1'b1;
      m_ferr = 1'b0;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  // per-cycle compare, paused briefly around each frame completion
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en && !rst) begin
        if (quiet > 0) quiet--;
        else chk("cycle", 32'({rx_data, rdy, frame_err, overrun}),
                 32'({m_data, m_rdy, m_ferr, m_ovr}));
      end
    end
  end

  // driver tasks: RX changes on falling clock edges, one bit every B clocks
  task automatic send_frame(input logic [7:0] b, input bit good, input bit tail);
    int  t0;
    int  off;
    bit  seen;
    @(negedge clk);
    rx = 1'b0;
    t0 = cyc;
    seen = 1'b0;
    lat_meas = -1;
    if (good) exp_q.push_back(b);
    while (cyc - t0 < LAT + 3) begin
      @(negedge clk);
      off = cyc - t0;
      if (off < B) rx = 1'b0;
      else if (off < 9 * B) rx = b[(off - B) / B];
      else rx = good;
      if (off == LAT - 2) quiet = 6;
      if (rdy && !seen) begin
        seen = 1'b1;
        lat_meas = off;
      end
    end
    model_frame(good);
    if (tail) begin
      rx = 1'b1;
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic send_glitch(input int len);
    @(negedge clk);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_rdy = 1'b1;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  task automatic reset_midframe(input logic [7:0] b);
    int t0;
    int off;
    @(negedge clk);
    rx = 1'b0;
    t0 = cyc;
    while (cyc - t0 < 5 * B + B / 2) begin
      @(negedge clk);
      off = cyc - t0;
      if (off < B) rx = 1'b0;
      else rx = b[(off - B) / B];
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_data", 32'(rx_data), 32'h0);
    chk("rst_mid_rdy", 32'(rdy), 32'h0);
    chk("rst_mid_ferr", 32'(frame_err), 32'h0);
    chk("rst_mid_ovr", 32'(overrun), 32'h0);
    m_data = 8'h00;
    m_rdy = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    quiet = 0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (B) @(negedge clk);
  endtask

  // stimulus and literal expectations
  initial begin
    rst = 1'b1;
    rx = 1'b1;
    clr_rdy = 1'b0;
    m_data = 8'h00;
    m_rdy = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(rx_data), 32'h0);
    chk("reset_rdy", 32'(rdy), 32'h0);
    chk("reset_ferr", 32'(frame_err), 32'h0);
    chk("reset_ovr", 32'(overrun), 32'h0);
    chk("reset_state_idle", 32'(state_dbg), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    // first byte and latency from the falling start edge
    send_frame(8'h67, 1'b1, 1'b1);
    checks++;
    if (lat_meas < LAT - 1 || lat_meas > LAT + 1) begin
      errors++;
      $display("FAIL latency: got %0d clocks expected %0d +/-1", lat_meas, LAT);
    end
    chk("b67_data", 32'(rx_data), 32'h67);
    chk("b67_rdy", 32'(rdy), 32'h1);
    chk("b67_ferr", 32'(frame_err), 32'h0);
    chk("b67_ovr", 32'(overrun), 32'h0);

    pulse_clr();
    chk("clr_rdy_low", 32'(rdy), 32'h0);
    send_frame(8'h73, 1'b1, 1'b1);
    chk("b73_data", 32'(rx_data), 32'h73);
    chk("b73_rdy", 32'(rdy), 32'h1);

    // short low pulse is rejected as a false start
    send_glitch(B / 2 - 4);
    chk("glitch_data", 32'(rx_data), 32'h73);
    chk("glitch_rdy", 32'(rdy), 32'h1);
    chk("glitch_ferr", 32'(frame_err), 32'h0);
    pulse_clr();
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("bA5_data", 32'(rx_data), 32'hA5);
    chk("bA5_rdy", 32'(rdy), 32'h1);

    // bad stop bit, then recovery
    pulse_clr();
    send_frame(8'h55, 1'b0, 1'b1);
    chk("bad55_ferr", 32'(frame_err), 32'h1);
    chk("bad55_rdy", 32'(rdy), 32'h0);
    chk("bad55_data", 32'(rx_data), 32'hA5);
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("b3C_ferr", 32'(frame_err), 32'h0);
    chk("b3C_rdy", 32'(rdy), 32'h1);
    chk("b3C_data", 32'(rx_data), 32'h3C);

    // back-to-back frames without acknowledge
    pulse_clr();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    chk("b2b_data", 32'(rx_data), 32'h22);
    chk("b2b_rdy", 32'(rdy), 32'h1);
    chk("b2b_ovr", 32'(overrun), 32'h1);
    pulse_clr();
    chk("b2b_clr_rdy", 32'(rdy), 32'h0);
    chk("b2b_clr_ovr", 32'(overrun), 32'h0);

    // reset during data bit 4, then a clean frame
    send_frame(8'h9E, 1'b1, 1'b1);
    reset_midframe(8'hC3);
    send_frame(8'hF0, 1'b1, 1'b1);
    chk("bF0_data", 32'(rx_data), 32'hF0);
    chk("bF0_rdy", 32'(rdy), 32'h1);
    chk("bF0_ferr", 32'(frame_err), 32'h0);

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
